// File: rtl/chess_clock_core.sv
// Chess clock engine: debounced buttons, two decisecond countdowns, packed status words.
// Define CHESS_CLOCK_INCREMENT_EN to add INCREMENT_DS to the mover's time on each move.

module chess_clock_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic press
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw_n;
            sync2   <= sync1;
            level_d <= level;
            press   <= level_d & ~level;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module chess_clock_core #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned TICK_HZ         = 10,
    parameter int unsigned DEFAULT_TIME_DS = 3000,
    parameter int unsigned INCREMENT_DS    = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk_clk,
    input  logic        reset_n,
    input  logic        btn_a_n,
    input  logic        btn_b_n,
    input  logic        btn_start_n,
    input  logic        btn_new_n,
    output logic [31:0] clock_time_export,
    output logic [31:0] clock_mode_export,
    output logic        tick_pulse
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
`ifdef CHESS_CLOCK_INCREMENT_EN
    localparam bit INC_ON = 1'b1;
`else
    localparam bit INC_ON = 1'b0;
`endif
    localparam logic [15:0] INC  = INC_ON ? 16'(INCREMENT_DS) : 16'd0;
    localparam logic [15:0] TIME0 = 16'(DEFAULT_TIME_DS);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, FLAG = 2'd3} state_t;

    state_t        state;
    logic          active;
    logic          flag_a;
    logic          flag_b;
    logic [15:0]   time_a;
    logic [15:0]   time_b;
    logic [15:0]   moves;
    logic [PW-1:0] presc;

    logic press_a;
    logic press_b;
    logic press_start;
    logic press_new;

    chess_clock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clk(clk_clk), .rst_n(reset_n), .raw_n(btn_a_n), .press(press_a));
    chess_clock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clk(clk_clk), .rst_n(reset_n), .raw_n(btn_b_n), .press(press_b));
    chess_clock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk_clk), .rst_n(reset_n), .raw_n(btn_start_n), .press(press_start));
    chess_clock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_new (
        .clk(clk_clk), .rst_n(reset_n), .raw_n(btn_new_n), .press(press_new));

    logic        tick_now;
    logic        move_now;
    logic [15:0] cur;
    logic [15:0] dec;
    logic [16:0] sum;
    logic [15:0] moved;

    // Tick is applied before the move, so the mover's increment lands on the decremented time.
    always_comb begin
        cur      = active ? time_b : time_a;
        tick_now = (state == RUN) && (presc == PW'(DIV - 1));
        dec      = (tick_now && cur != 16'd0) ? cur - 16'd1 : cur;
        move_now = active ? press_b : press_a;
        sum      = {1'b0, dec} + {1'b0, INC};
        moved    = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            active     <= 1'b0;
            flag_a     <= 1'b0;
            flag_b     <= 1'b0;
            time_a     <= TIME0;
            time_b     <= TIME0;
            moves      <= '0;
            presc      <= '0;
            tick_pulse <= 1'b0;
        end else begin
            tick_pulse <= 1'b0;
            if (press_new) begin
                state  <= IDLE;
                active <= 1'b0;
                flag_a <= 1'b0;
                flag_b <= 1'b0;
                time_a <= TIME0;
                time_b <= TIME0;
                moves  <= '0;
                presc  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        if (press_start) begin
                            state  <= RUN;
                            active <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (tick_now) begin
                            tick_pulse <= 1'b1;
                            presc      <= '0;
                        end else begin
                            presc <= presc + PW'(1);
                        end
                        if (tick_now && dec == 16'd0) begin
                            state <= FLAG;
                            presc <= '0;
                            if (active) begin
                                time_b <= '0;
                                flag_b <= 1'b1;
                            end else begin
                                time_a <= '0;
                                flag_a <= 1'b1;
                            end
                        end else if (move_now) begin
                            if (active) time_b <= moved;
                            else        time_a <= moved;
                            active <= ~active;
                            moves  <= (moves == 16'hFFFF) ? moves : moves + 16'd1;
                            presc  <= '0;
                        end else begin
                            if (active) time_b <= dec;
                            else        time_a <= dec;
                            if (press_start) state <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (press_start) state <= RUN;
                    end
                    default: begin
                        presc <= '0;
                    end
                endcase
            end
        end
    end

    assign clock_time_export = {time_b, time_a};
    assign clock_mode_export = {moves, 8'h00, 3'b000, flag_b, flag_a, active, state};
endmodule

// File: tb/tb_chess_clock_core.sv
// Directed scoreboard bench for chess_clock_core with a 10-cycle tick and 3-sample debounce.
// Expected values depend on CHESS_CLOCK_INCREMENT_EN in the same way as the design.

module tb_chess_clock_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  btn_n = 4'hF;   // {new, start, b, a}
    logic [31:0] clock_time_export;
    logic [31:0] clock_mode_export;
    logic        tick_pulse;

    localparam logic [3:0] B_A = 4'b0001, B_B = 4'b0010, B_START = 4'b0100, B_NEW = 4'b1000;
`ifdef CHESS_CLOCK_INCREMENT_EN
    localparam logic [15:0] A_AFTER_MOVE = 16'd6;
`else
    localparam logic [15:0] A_AFTER_MOVE = 16'd4;
`endif

    chess_clock_core #(
        .CLK_HZ(100),
        .TICK_HZ(10),
        .DEFAULT_TIME_DS(5),
        .INCREMENT_DS(2),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk_clk(clk),
        .reset_n(reset_n),
        .btn_a_n(btn_n[0]),
        .btn_b_n(btn_n[1]),
        .btn_start_n(btn_n[2]),
        .btn_new_n(btn_n[3]),
        .clock_time_export(clock_time_export),
        .clock_mode_export(clock_mode_export),
        .tick_pulse(tick_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int passed = 0;
    int failed = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_tm(input string tag, input logic [31:0] t, input logic [31:0] m);
        push({tag, "_time"}, 0, t);
        push({tag, "_mode"}, 1, m);
    endtask

    task automatic check_pending();
        sb_entry_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       obs = clock_time_export;
                1:       obs = clock_mode_export;
                default: obs = {31'd0, tick_pulse};
            endcase
            assert (obs === e.exp) begin
                passed++;
            end else begin
                failed++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Drive the given buttons low for hold cycles, then release them all.
    task automatic press(input logic [3:0] mask, input int hold);
        btn_n = ~mask;
        step(hold);
        btn_n = 4'hF;
    endtask

    initial begin
        step(3);
        push_tm("in_reset", 32'h00050005, 32'h0);
        check_pending();
        reset_n = 1'b1;
        step(2);
        push_tm("reset", 32'h00050005, 32'h0);
        push("reset_tick", 2, 32'd0);
        check_pending();

        // Countdown to flag on A
        press(B_START, 4); step(3);
        push("start_run", 1, 32'h1);
        check_pending();
        step(30);
        push("run30", 0, 32'h00050002);
        push("tick_on", 2, 32'd1);
        check_pending();
        step(1);
        push("tick_off", 2, 32'd0);
        check_pending();
        step(19);
        push_tm("flag_a", 32'h00050000, 32'h0000000B);
        push("flag_tick", 2, 32'd1);
        check_pending();
        press(B_A, 4); step(6);
        press(B_B, 4); step(6);
        press(B_START, 4); step(6);
        push_tm("flag_frozen", 32'h00050000, 32'h0000000B);
        push("flag_no_tick", 2, 32'd0);
        check_pending();
        press(B_NEW, 4); step(3);
        push_tm("new_from_flag", 32'h00050005, 32'h0);
        check_pending();

        // Move with optional increment; inactive player ignored
        press(B_START, 4); step(3);
        step(10);
        push("pre_move", 0, 32'h00050004);
        check_pending();
        press(B_A, 4); step(3);
        push_tm("move_a", {16'd5, A_AFTER_MOVE}, 32'h00010005);
        check_pending();
        step(4);
        press(B_A, 4); step(3);
        push_tm("inactive_a", {16'd4, A_AFTER_MOVE}, 32'h00010005);
        check_pending();
        press(B_NEW, 4); step(3);
        push_tm("new_after_move", 32'h00050005, 32'h0);
        check_pending();

        // Pause holds the prescaler
        press(B_START, 4); step(3);
        step(8);
        press(B_START, 4); step(3);
        push_tm("paused", 32'h00050004, 32'h2);
        check_pending();
        step(100);
        push_tm("pause_hold", 32'h00050004, 32'h2);
        check_pending();
        press(B_START, 4); step(3);
        push_tm("resume", 32'h00050004, 32'h1);
        check_pending();
        step(4);
        push("resume_4", 0, 32'h00050004);
        push("resume_4_tick", 2, 32'd0);
        check_pending();
        step(1);
        push("resume_5", 0, 32'h00050003);
        push("resume_5_tick", 2, 32'd1);
        check_pending();
        press(B_NEW, 4); step(3);
        push_tm("new_after_pause", 32'h00050005, 32'h0);
        check_pending();

        // Debounce: glitch rejected, 3-sample press accepted with exact latency
        press(B_START, 2); step(10);
        push("glitch", 1, 32'h0);
        check_pending();
        press(B_START, 3); step(3);
        push("latency_m1", 1, 32'h0);
        check_pending();
        step(1);
        push("latency", 1, 32'h1);
        check_pending();

        // New-game beats a simultaneous active-player move
        step(5);
        press(B_NEW | B_A, 4); step(3);
        push_tm("new_vs_move", 32'h00050005, 32'h0);
        check_pending();

        // Asynchronous reset mid-run
        press(B_START, 4); step(3);
        step(15);
        push("prereset", 1, 32'h1);
        check_pending();
        reset_n = 1'b0;
        #1;
        push_tm("async_reset", 32'h00050005, 32'h0);
        push("async_reset_tick", 2, 32'd0);
        check_pending();
        step(2);
        reset_n = 1'b1;
        step(2);
        push_tm("post_reset", 32'h00050005, 32'h0);
        check_pending();

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end
endmodule

// File: doc/chess_clock_core.md
Name: chess_clock_core

Overview:
- Fabric-side chess clock engine for the DE10-Standard GHRD. It debounces the player, start/pause and new-game buttons, and runs two countdown timers in deciseconds.
- It packs game state into two 32-bit words. These drive the HPS-visible PIO inputs pio_external_clock_time_export and pio_external_clock_mode_export, which sit directly downstream.
- Purely sequential producer; no bus interface.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 10, countdown resolution (10 = deciseconds). Divisor = CLK_HZ/TICK_HZ, integer, must be >= 2.
- DEFAULT_TIME_DS, 3000, per-player starting time in ticks, 16-bit.
- INCREMENT_DS, 20, ticks added to the mover on each move (feature-gated).
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a button level.

Ports:
- clk_clk, input, 1, system clock (50 MHz on board).
- reset_n, input, 1, asynchronous active-low reset, synchronously deasserted upstream.
- btn_a_n, input, 1, player A move button, raw, active-low.
- btn_b_n, input, 1, player B move button, raw, active-low.
- btn_start_n, input, 1, start/pause toggle, raw, active-low.
- btn_new_n, input, 1, new game, raw, active-low.
- clock_time_export, output, 32, [15:0] A remaining ticks; [31:16] B remaining ticks.
- clock_mode_export, output, 32:
  - [1:0] state: 0 IDLE, 1 RUN, 2 PAUSE, 3 FLAG.
  - [2] active player (0 = A).
  - [3] A flagged; [4] B flagged.
  - [7:5] 0.
  - [15:8] 0.
  - [31:16] move count.
- tick_pulse, output, 1, one-cycle strobe on each countdown decrement (debug/LED).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, active=A, times={DEFAULT_TIME_DS, DEFAULT_TIME_DS}, move count 0, flags 0, tick_pulse 0, prescaler 0.
  - Debouncers hold "released".
- Button path, per button:
  - 2-FF synchronizer, then debounce counter. The accepted level changes only after DEBOUNCE_CYCLES consecutive samples differ from it; any mismatch-free gap restarts the count.
  - Press event = one-cycle pulse on accepted 1->0 transition. Releases produce no event.
- Press-to-output latency: exactly DEBOUNCE_CYCLES+4 clk_clk cycles from the raw edge.
- Outputs are fully registered, with no combinational path from inputs.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1, only while state=RUN.
  - Holds its value in PAUSE; cleared in IDLE/FLAG and on every accepted move.
  - A tick fires when the count wraps.
- State transitions:
  - IDLE: start -> RUN (active=A). Player buttons are ignored.
  - RUN:
    - Tick decrements the active time by 1.
    - If the result is 0: state=FLAG, set that player's flag, time stays 0, no further ticks.
    - Press of the active player's button: add increment (saturate at 0xFFFF), toggle active, move count +1 (saturate at 0xFFFF).
    - The inactive player's button is ignored.
    - Start -> PAUSE.
  - PAUSE: start -> RUN, prescaler resumes from its held value. Player buttons are ignored.
  - FLAG: terminal; only new-game exits.
  - new-game (any state) -> IDLE, times reloaded to DEFAULT_TIME_DS, move count 0, flags 0, active=A.
- Same-cycle priority:
  - new-game > tick > move > start.
  - Tick + move in the same cycle: decrement the mover first. If it reaches 0 -> FLAG and the move is discarded. Otherwise apply the increment to the decremented value and switch.
  - Move + start in the same cycle: the move is applied and start is ignored.
  - Both player buttons in the same cycle: only the active player's press counts.
- Time arithmetic: unsigned 16-bit, no underflow below 0, increment saturates.

Optional Feature:
- CHESS_CLOCK_INCREMENT_EN, when defined: Fischer increment; each accepted move adds INCREMENT_DS to the mover's time, with saturation.
- When not defined: moves only switch the active player and count; INCREMENT_DS is unused and times never increase except on new-game.

Test Plan:
- Bench parameters: CLK_HZ=100, TICK_HZ=10 (divisor 10), DEFAULT_TIME_DS=5, INCREMENT_DS=2, DEBOUNCE_CYCLES=3.
- Reset: reset_n low mid-run, then release -> time=0x00050005, mode=0x00000000, tick_pulse=0.
- Start pressed: mode[1:0]=1. After 30 cycles, A=2, B=5. After a further 20 cycles, A=0, mode[1:0]=3, mode[3]=1; later presses of A/B/start do not change outputs.
- Move with increment: start, wait 10 cycles (A=4), press A -> A=6 (increment defined) or 4 (undefined), active=B, mode[31:16]=1. Pressing A again changes nothing.
- Pause: run 15 cycles (A=4, prescaler=5), start -> PAUSE, hold 100 cycles with A=4. Start again -> next A decrement occurs 5 cycles later.
- Debounce: a 2-cycle glitch on btn_start_n gives no state change. A stable 3-cycle press gives state=RUN exactly DEBOUNCE_CYCLES+4 cycles after the raw edge.
- Priority: new-game and A-move in the same cycle during RUN -> IDLE, time=0x00050005, move count 0.
